// File: rtl/merge2_arb_if.sv
// Handshake bundle for merge2_arb: two upstream flit ports and one downstream FIFO port.
// The slave modport is the merge block's view; master is the surrounding fabric.
interface merge2_arb_if #(
   parameter int unsigned W = 9
);
   logic [W-1:0] in0_data;
   logic         in0_valid;
   logic         in0_ready;
   logic [W-1:0] in1_data;
   logic         in1_valid;
   logic         in1_ready;
   logic [W-1:0] out_data;
   logic         out_src;
   logic         out_valid;
   logic         out_ready;

   modport slave (
      input  in0_data, in0_valid,
      output in0_ready,
      input  in1_data, in1_valid,
      output in1_ready,
      output out_data, out_src, out_valid,
      input  out_ready
   );

   modport master (
      output in0_data, in0_valid,
      input  in0_ready,
      output in1_data, in1_valid,
      input  in1_ready,
      input  out_data, out_src, out_valid,
      output out_ready
   );
endinterface

// File: rtl/merge2_arb.sv
// Two-input flit merge: one grant per cycle into a small tagged output FIFO.
// Define ARB_ROUNDROBIN_EN for round-robin on contention; default is fixed priority to port 0.
module merge2_arb #(
   parameter int unsigned W     = 9,
   parameter int unsigned DEPTH = 2
) (
   input logic        clk,
   input logic        reset,
   merge2_arb_if.slave bus
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [W:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          last;

   logic          full;
   logic          not_empty;
   logic          prefer1;
   logic          grant0;
   logic          grant1;
   logic          push;
   logic          pop;
   logic [W:0]    push_entry;

   assign full      = (count == FullCount);
   assign not_empty = (count != '0);

`ifdef ARB_ROUNDROBIN_EN
   assign prefer1 = ~last;
`else
   // Fixed priority: last is tracked but never steers the grant.
   assign prefer1 = last & 1'b0;
`endif

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset && !full) begin
         if (bus.in0_valid && bus.in1_valid) begin
            grant1 = prefer1;
            grant0 = ~prefer1;
         end else begin
            grant0 = bus.in0_valid;
            grant1 = bus.in1_valid;
         end
      end
   end

   always_comb begin
      push       = (grant0 & bus.in0_valid) | (grant1 & bus.in1_valid);
      pop        = not_empty & bus.out_ready;
      push_entry = grant1 ? {1'b1, bus.in1_data} : {1'b0, bus.in0_data};
   end

   assign bus.in0_ready = grant0;
   assign bus.in1_ready = grant1;
   assign bus.out_valid = not_empty;
   assign bus.out_data  = mem[rd_ptr][W-1:0];
   assign bus.out_src   = mem[rd_ptr][W];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last   <= 1'b1;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
            last        <= push_entry[W];
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
